adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Synthesizable model of an LTC2308-style 8-channel, 12-bit SPI ADC: it responds to CONVST/SCK/SDI from the ADC controller and drives SDO. Sample values come from an Avalon-ST sink into an 8-entry sample bank. It sits on the far side of the ADC pins and stands in for the real converter in simulation and in FPGA loopback builds, so the controller and its streaming/readout path can be exercised end-to-end without the board ADC.

## Interface
Parameters:
- CONV_CYCLES, 80, conversion time in slave_clk cycles (1.6 µs at 50 MHz)
- DATA_WIDTH, 12, sample and frame width
- SYNC_STAGES, 2, synchronizer depth on CONVST/SCK/SDI

Ports:
- slave_clk  in  1  sole clock; CONVST/SCK/SDI are asynchronous to it and oversampled
- slave_reset  in  1  asynchronous, active-high
- CONVST  in  1  conversion start from controller
- SCK  in  1  serial clock from controller
- SDI  in  1  config word from controller, MSB first
- SDO  out  1  conversion result to controller, MSB first
- streaming_sink_data  in  12  sample value
- streaming_sink_channel  in  3  sample-bank index
- streaming_sink_valid  in  1  write strobe
- streaming_sink_ready  out  1  constant 1 out of reset
- busy  out  1  high during CONVERT
- protocol_error  out  1  sticky violation flag; see Configuration

## Operation
- Config word, 6 bits: [5] S/D, [4] O/S, [3] S1, [2] S0, [1] UNI, [0] SLP. Selected channel = {O/S,S1,S0}. S/D and SLP are stored but ignored. Reset config = 6'b100010: channel 0, unipolar.
- Sample bank: 8×12 registers, all reset to 0. Written when valid && ready. A write takes effect the cycle after the strobe.
- States:
  - IDLE: waits for CONVST rise.
  - CONVERT: on CONVST rise, latch bank[active channel] into the 12-bit shift register and count CONV_CYCLES. Result = sample if UNI=1, else sample ^ 12'h800.
  - SHIFT: entered when the count expires; SDO = bit 11 immediately. On each SCK falling edge, shift left and present the next bit. On each SCK rising edge, shift SDI into the config shifter.
  - After the 12th SCK fall: SDO = 0 and return to IDLE.
- Config word commits on the 6th SCK rise and applies to the next conversion only.
- Boundary cases:
  - CONVST rise during SHIFT: aborts the frame. Config commits only if ≥6 bits were already captured. Restarts CONVERT.
  - CONVST rise during CONVERT: ignored.
  - SCK edges during CONVERT or IDLE: ignored.
  - Frame with fewer than 6 SCK rises: config is unchanged.
  - Sink write to the channel being latched, in the same cycle: the old value is latched.
  - slave_reset mid-frame: immediate return to IDLE, bank and config reset.

## Timing
- Reset values: SDO=0, busy=0, protocol_error=0, streaming_sink_ready=1, state IDLE.
- Edge detect latency: SYNC_STAGES+1 cycles from pin edge to internal pulse. SCK high and low phases must each be ≥ SYNC_STAGES+2 cycles.
- busy rises SYNC_STAGES+1 cycles after CONVST rises and stays high for exactly CONV_CYCLES cycles.
- SDO MSB valid on the cycle busy falls.
- Each later SDO bit updates SYNC_STAGES+1 cycles after its SCK fall. The controller samples it on the next SCK rise.

## Configuration
- ADC_RESP_PROTOCOL_CHECK_EN defined:
  - protocol_error is set by any of: CONVST rise during CONVERT; SCK edge during CONVERT; frame aborted with fewer than 12 bits.
  - Cleared only by reset.
- Not defined: protocol_error is tied to 0 and the check logic is absent. Functional behaviour is otherwise identical.

## Structure
- Package adc_resp_pkg:
  - state enum (IDLE, CONVERT, SHIFT)
  - config bit index constants
  - RESET_CONFIG = 6'b100010
  - NUM_CHANNELS = 8
- One sub-module, adc_resp_sync_edge: SYNC_STAGES flop synchronizer plus rise/fall pulse outputs. Instantiated for CONVST and SCK. SDI uses its synchronized level only.

## Test plan
- Reset → SDO=0, busy=0, ready=1. A frame with the bank empty returns 12'h000.
- Write ch0=12'hABC, pulse CONVST, 12 SCK with SDI=0 → SDO sequence 1010_1011_1100. The next frame reads ch0 bipolar (config 000000): 12'h2BC.
- Write ch5=12'h123. Frame 1 sends SDI=6'b110100 (ch5, bipolar). Frame 2 → SDO = 12'h923.
- Truncated frame with 4 SCK, then CONVST → config unchanged, next result is from the previous channel. With the macro defined, protocol_error=1.
- CONVST re-pulsed 20 cycles into CONVERT → busy width stays CONV_CYCLES, result unchanged. protocol_error=1 only with the macro.
- Sink write ch0=12'h555 in the same cycle as the latch (old value 12'h111) → frame returns 12'h111, and the following frame returns 12'h555.

Source files
------------

// File: rtl/adc_resp_pkg.sv
// rtl/adc_resp_pkg.sv - shared types and constants for the SPI ADC responder
package adc_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SHIFT
    } state_t;

    localparam int CFG_WIDTH = 6;
    localparam int CFG_SD    = 5;
    localparam int CFG_OS    = 4;
    localparam int CFG_S1    = 3;
    localparam int CFG_S0    = 2;
    localparam int CFG_UNI   = 1;
    localparam int CFG_SLP   = 0;

    localparam logic [CFG_WIDTH-1:0] RESET_CONFIG = 6'b100010;

    localparam int NUM_CHANNELS = 8;
    localparam int CH_WIDTH     = 3;

    function automatic logic [CH_WIDTH-1:0] cfg_channel(input logic [CFG_WIDTH-1:0] cfg);
        return {cfg[CFG_OS], cfg[CFG_S1], cfg[CFG_S0]};
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// rtl/adc_spi_responder_if.sv - ADC pin bundle plus sample-bank sink
interface adc_spi_responder_if
    import adc_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 12
);
    logic                  CONVST;
    logic                  SCK;
    logic                  SDI;
    logic                  SDO;
    logic [DATA_WIDTH-1:0] streaming_sink_data;
    logic [CH_WIDTH-1:0]   streaming_sink_channel;
    logic                  streaming_sink_valid;
    logic                  streaming_sink_ready;

    modport master (
        output CONVST, SCK, SDI,
        output streaming_sink_data, streaming_sink_channel, streaming_sink_valid,
        input  SDO, streaming_sink_ready
    );

    modport slave (
        input  CONVST, SCK, SDI,
        input  streaming_sink_data, streaming_sink_channel, streaming_sink_valid,
        output SDO, streaming_sink_ready
    );
endinterface

// File: rtl/adc_resp_sync_edge.sv
// rtl/adc_resp_sync_edge.sv - flop synchronizer with rise/fall pulses
module adc_resp_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - LTC2308-style SPI ADC stand-in fed from an 8-entry sample bank
// Optional protocol checker: ADC_RESP_PROTOCOL_CHECK_EN
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int CONV_CYCLES = 80,
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 slave_clk,
    input  logic                 slave_reset,
    adc_spi_responder_if.slave   bus,
    output logic                 busy,
    output logic                 protocol_error
);
    localparam int CNT_W  = $clog2(CONV_CYCLES + 1);
    localparam int FALL_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] SIGN_FLIP = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic convst_rise, convst_fall, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] sdi_sync;

    adc_resp_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_convst (
        .clk(slave_clk), .rst(slave_reset), .din(bus.CONVST),
        .rise(convst_rise), .fall(convst_fall)
    );

    adc_resp_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(slave_clk), .rst(slave_reset), .din(bus.SCK),
        .rise(sck_rise), .fall(sck_fall)
    );

    // Same depth as SCK so the SDI level lines up with the sck_rise pulse
    always_ff @(posedge slave_clk or posedge slave_reset) begin
        if (slave_reset) begin
            sdi_sync <= '0;
        end else begin
            sdi_sync[0] <= bus.SDI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sdi_sync[i] <= sdi_sync[i-1];
            end
        end
    end

    logic [DATA_WIDTH-1:0] bank [NUM_CHANNELS];

    assign bus.streaming_sink_ready = 1'b1;

    always_ff @(posedge slave_clk or posedge slave_reset) begin
        if (slave_reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                bank[i] <= '0;
            end
        end else if (bus.streaming_sink_valid && bus.streaming_sink_ready) begin
            bank[bus.streaming_sink_channel] <= bus.streaming_sink_data;
        end
    end

    state_t                state;
    logic [CNT_W-1:0]      conv_cnt;
    logic [FALL_W-1:0]     fall_cnt;
    logic [2:0]            rise_cnt;
    logic [CFG_WIDTH-2:0]  cfg_sh;
    logic [CFG_WIDTH-1:0]  config_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  sdo_q;
    logic [DATA_WIDTH-1:0] sel_sample;
    logic [DATA_WIDTH-1:0] conv_result;
    logic                  start_conv;

    // Bank read sees pre-write contents, so a same-cycle sink write is not latched
    assign sel_sample  = bank[cfg_channel(config_q)];
    assign conv_result = config_q[CFG_UNI] ? sel_sample : (sel_sample ^ SIGN_FLIP);
    assign start_conv  = convst_rise && (state == IDLE || state == SHIFT);
    assign bus.SDO     = sdo_q;

    always_ff @(posedge slave_clk or posedge slave_reset) begin
        if (slave_reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sdo_q    <= 1'b0;
            shreg    <= '0;
            conv_cnt <= '0;
            fall_cnt <= '0;
            rise_cnt <= '0;
            cfg_sh   <= '0;
            config_q <= RESET_CONFIG;
        end else if (start_conv) begin
            state    <= CONVERT;
            busy     <= 1'b1;
            sdo_q    <= 1'b0;
            shreg    <= conv_result;
            conv_cnt <= CNT_W'(CONV_CYCLES - 1);
            fall_cnt <= '0;
            rise_cnt <= '0;
        end else begin
            case (state)
                CONVERT: begin
                    if (conv_cnt == '0) begin
                        state <= SHIFT;
                        busy  <= 1'b0;
                        sdo_q <= shreg[DATA_WIDTH-1];
                    end else begin
                        conv_cnt <= conv_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (sck_rise && rise_cnt != 3'(CFG_WIDTH)) begin
                        cfg_sh   <= {cfg_sh[CFG_WIDTH-3:0], sdi_sync[SYNC_STAGES-1]};
                        rise_cnt <= rise_cnt + 1'b1;
                        if (rise_cnt == 3'(CFG_WIDTH - 1)) begin
                            config_q <= {cfg_sh, sdi_sync[SYNC_STAGES-1]};
                        end
                    end
                    if (sck_fall) begin
                        if (fall_cnt == FALL_W'(DATA_WIDTH - 1)) begin
                            sdo_q <= 1'b0;
                            state <= IDLE;
                        end else begin
                            fall_cnt <= fall_cnt + 1'b1;
                            shreg    <= shreg << 1;
                            sdo_q    <= shreg[DATA_WIDTH-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_RESP_PROTOCOL_CHECK_EN
    // Any abort out of SHIFT is short by definition: a complete frame already left for IDLE
    always_ff @(posedge slave_clk or posedge slave_reset) begin
        if (slave_reset) begin
            protocol_error <= 1'b0;
        end else if ((state == CONVERT && (convst_rise || sck_rise || sck_fall)) ||
                     (state == SHIFT && convst_rise)) begin
            protocol_error <= 1'b1;
        end
    end
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - table-driven and scoreboarded checks of adc_spi_responder
module tb_adc_spi_responder;
    import adc_resp_pkg::*;

    localparam int SS = 2;
    localparam int CC = 80;
    localparam int DW = 12;
`ifdef ADC_RESP_PROTOCOL_CHECK_EN
    localparam logic PE_EXP = 1'b1;
`else
    localparam logic PE_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, pe;

    always #5 clk = ~clk;

    adc_spi_responder_if #(.DATA_WIDTH(DW)) bus ();

    adc_spi_responder #(.CONV_CYCLES(CC), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .slave_clk(clk),
        .slave_reset(rst),
        .bus(bus),
        .busy(busy),
        .protocol_error(pe)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [2:0]  wch;
        logic [11:0] wdata;
        logic [5:0]  cfg;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sink_write(input logic [2:0] ch, input logic [11:0] data);
        bus.streaming_sink_channel = ch;
        bus.streaming_sink_data    = data;
        bus.streaming_sink_valid   = 1'b1;
        tick();
        bus.streaming_sink_valid   = 1'b0;
    endtask

    task automatic wait_busy_low(output int width);
        width = busy ? 1 : 0;
        while (busy && width < 200) begin
            tick();
            if (busy) width++;
        end
    endtask

    task automatic start_conv(output int lat, output int width);
        bus.CONVST = 1'b1;
        lat = 0;
        while (!busy && lat < 20) begin
            tick();
            lat++;
        end
        bus.CONVST = 1'b0;
        wait_busy_low(width);
    endtask

    task automatic shift_bits(input logic [5:0] cfg, input int nsck, output logic [11:0] got);
        got = '0;
        for (int i = 0; i < nsck; i++) begin
            bus.SDI = (i < 6) ? cfg[5-i] : 1'b0;
            repeat (6) tick();
            got = {got[10:0], bus.SDO};
            bus.SCK = 1'b1;
            repeat (6) tick();
            bus.SCK = 1'b0;
        end
        bus.SDI = 1'b0;
        repeat (6) tick();
    endtask

    task automatic pop_check(input string name, input logic [11:0] got);
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            check(name, got, exp_q.pop_front());
        end
    endtask

    task automatic run_frame(input string name, input logic [5:0] cfg, input logic [11:0] exp);
        int lat, width;
        logic [11:0] got;
        exp_q.push_back(exp);
        start_conv(lat, width);
        check({name, "_busy_lat"}, lat, SS + 1);
        check({name, "_busy_width"}, width, CC);
        shift_bits(cfg, 12, got);
        pop_check(name, got);
        check({name, "_sdo_idle"}, bus.SDO, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, width;
        logic [11:0] got;

        bus.CONVST = 1'b0;
        bus.SCK    = 1'b0;
        bus.SDI    = 1'b0;
        bus.streaming_sink_data    = '0;
        bus.streaming_sink_channel = '0;
        bus.streaming_sink_valid   = 1'b0;

        vecs[0] = '{1'b1, 3'd0, 12'hABC, 6'b000000, 12'hABC};
        vecs[1] = '{1'b1, 3'd5, 12'h123, 6'b110100, 12'h2BC};
        vecs[2] = '{1'b0, 3'd0, 12'h000, 6'b100110, 12'h923};
        vecs[3] = '{1'b1, 3'd1, 12'hFFF, 6'b111110, 12'hFFF};
        vecs[4] = '{1'b0, 3'd0, 12'h000, 6'b101100, 12'h000};
        vecs[5] = '{1'b1, 3'd3, 12'h7FF, 6'b000010, 12'hFFF};
        vecs[6] = '{1'b1, 3'd0, 12'h001, 6'b000010, 12'h001};

        repeat (3) tick();
        check("reset_sdo", bus.SDO, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", bus.streaming_sink_ready, 1'b1);
        check("reset_perr", pe, 1'b0);
        rst = 1'b0;
        tick();

        run_frame("empty_bank", 6'b100010, 12'h000);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) sink_write(vecs[i].wch, vecs[i].wdata);
            run_frame($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].exp);
        end
        check("perr_clean_frames", pe, 1'b0);

        // Truncated to 4 SCKs: config must stay ch0 unipolar
        sink_write(3'd2, 12'h456);
        start_conv(lat, width);
        shift_bits(6'b001010, 4, got);
        check("trunc_partial_bits", got[3:0], 4'h0);
        run_frame("after_trunc4", 6'b000010, 12'h001);
        check("trunc_perr", pe, PE_EXP);

        // Aborted after 8 SCKs: six config bits were captured, so ch2 commits
        start_conv(lat, width);
        shift_bits(6'b001010, 8, got);
        check("abort8_partial_bits", got[7:0], 8'h00);
        run_frame("after_abort8", 6'b001010, 12'h456);

        // Reset asserted mid-frame
        start_conv(lat, width);
        shift_bits(6'b001010, 1, got);
        check("midframe_sdo_bit10", bus.SDO, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_sdo", bus.SDO, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_perr", pe, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_frame("post_reset_bank", 6'b100010, 12'h000);
        check("post_reset_perr", pe, 1'b0);

        // CONVST re-pulsed 20 cycles into CONVERT
        sink_write(3'd0, 12'h111);
        exp_q.push_back(12'h111);
        bus.CONVST = 1'b1;
        lat = 0;
        while (!busy && lat < 20) begin
            tick();
            lat++;
        end
        bus.CONVST = 1'b0;
        width = busy ? 1 : 0;
        while (busy && width < 200) begin
            if (width == 20) bus.CONVST = 1'b1;
            if (width == 24) bus.CONVST = 1'b0;
            tick();
            if (busy) width++;
        end
        bus.CONVST = 1'b0;
        check("repulse_busy_width", width, CC);
        shift_bits(6'b100010, 12, got);
        pop_check("repulse_result", got);
        check("repulse_perr", pe, PE_EXP);

        // Sink write to ch0 on the very edge that latches ch0
        exp_q.push_back(12'h111);
        bus.CONVST = 1'b1;
        tick();
        tick();
        bus.streaming_sink_channel = 3'd0;
        bus.streaming_sink_data    = 12'h555;
        bus.streaming_sink_valid   = 1'b1;
        tick();
        bus.streaming_sink_valid   = 1'b0;
        check("collide_busy_edge", busy, 1'b1);
        bus.CONVST = 1'b0;
        wait_busy_low(width);
        check("collide_busy_width", width, CC);
        shift_bits(6'b100010, 12, got);
        pop_check("collide_old_value", got);
        run_frame("collide_new_value", 6'b100010, 12'h555);

        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
